// File: rtl/scarv_cop_palu_sched_pkg.sv
// Shared types for the packed-ALU scheduler: FSM encoding, packed op layout
// and the two-requester round-robin grant function.
package scarv_cop_palu_sched_pkg;

   localparam int OP_W = 172;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Field layout of the packed op, MSB first.
   typedef struct packed {
      logic [31:0] gpr_rs1;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] rs3;
      logic [31:0] imm;
      logic [2:0]  pw;
      logic [3:0]  cls;
      logic [4:0]  subclass;
   } op_t;

   // last = index of the previous winner; on a tie the other one wins.
   function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last);
      logic [1:0] g;
      g[0] = valid[0] & (~valid[1] | last);
      g[1] = valid[1] & (~valid[0] | ~last);
      return g;
   endfunction

endpackage

// File: rtl/scarv_cop_palu_sched_arb.sv
// Combinational two-way round-robin arbiter. avail[i] says requester i would
// win if it were valid, so it never depends on that requester's own valid.
module scarv_cop_palu_sched_arb
   import scarv_cop_palu_sched_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic [1:0] avail
);

   always_comb begin
      grant    = rr_grant(valid, last_grant);
      avail[0] = ~(valid[1] & ~last_grant);
      avail[1] = ~(valid[0] &  last_grant);
   end

endmodule

// File: rtl/scarv_cop_palu_sched.sv
// Scheduler/sequencer for the shared packed-ALU datapath.
// Optional EXEC watchdog enabled by SCARV_COP_PALU_SCHED_TIMEOUT_EN.
module scarv_cop_palu_sched
   import scarv_cop_palu_sched_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 64
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_op,
   input  logic [3:0]      req0_rd,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_op,
   input  logic [3:0]      req1_rd,
   output logic            palu_ivalid,
   output logic [OP_W-1:0] palu_op,
   input  logic            palu_idone,
   input  logic [3:0]      palu_cpr_rd_ben,
   input  logic [31:0]     palu_cpr_rd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_src,
   output logic [3:0]      rsp_rd,
   output logic [3:0]      rsp_ben,
   output logic [31:0]     rsp_wdata,
   output logic            rsp_err
);

   if (TMO_CYCLES < 1) begin : g_tmo_chk
      $error("TMO_CYCLES must be at least 1");
   end

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [3:0]        rd_q, rd_d;
   logic              src_q, src_d;
   logic [3:0]        ben_q, ben_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        grant, avail;
   logic              window, take, done, tmo_hit;

   scarv_cop_palu_sched_arb u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_q),
      .grant      (grant),
      .avail      (avail)
   );

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|grant)             state_d = EXEC;
         EXEC:    if (palu_idone || tmo_hit) state_d = RESP;
         RESP:    if (rsp_ready)          state_d = (|grant) ? EXEC : IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   always_comb begin
      window      = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
      req0_ready  = window & avail[0];
      req1_ready  = window & avail[1];
      palu_ivalid = (state_q == EXEC);
      rsp_valid   = (state_q == RESP);
   end

   assign take = window & (|grant);
   assign done = (state_q == EXEC) & palu_idone;

   always_comb begin
      last_d  = last_q;
      op_d    = op_q;
      rd_d    = rd_q;
      src_d   = src_q;
      ben_d   = ben_q;
      wdata_d = wdata_q;
      if (take) begin
         last_d = grant[1];
         src_d  = grant[1];
         op_d   = grant[1] ? req1_op : req0_op;
         rd_d   = grant[1] ? req1_rd : req0_rd;
      end
      if (done) begin
         ben_d   = palu_cpr_rd_ben;
         wdata_d = palu_cpr_rd_wdata;
      end else if (tmo_hit) begin
         ben_d   = 4'h0;
         wdata_d = 32'h0;
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         last_q  <= 1'b1;
         op_q    <= '0;
         rd_q    <= '0;
         src_q   <= 1'b0;
         ben_q   <= '0;
         wdata_q <= '0;
      end else begin
         last_q  <= last_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         src_q   <= src_d;
         ben_q   <= ben_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef SCARV_COP_PALU_SCHED_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   // Counts EXEC cycles without idone; idone on the limit cycle still wins.
   assign tmo_hit = (state_q == EXEC) && !palu_idone && (cnt_q == TMO_CYCLES - 1);

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (take)                      cnt_d = '0;
      else if (state_q == EXEC && !palu_idone) cnt_d = cnt_q + 32'd1;
      if (take || done)              err_d = 1'b0;
      else if (tmo_hit)              err_d = 1'b1;
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rsp_err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign palu_op   = op_q;
   assign rsp_src   = src_q;
   assign rsp_rd    = rd_q;
   assign rsp_ben   = ben_q;
   assign rsp_wdata = wdata_q;

endmodule

// File: tb/tb_scarv_cop_palu_sched.sv
// Directed bench for scarv_cop_palu_sched; the watchdog case runs only when
// SCARV_COP_PALU_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_scarv_cop_palu_sched;
   import scarv_cop_palu_sched_pkg::*;

   logic            g_clk = 1'b0;
   logic            g_resetn = 1'b0;
   logic            req0_valid, req0_ready, req1_valid, req1_ready;
   logic [OP_W-1:0] req0_op, req1_op, palu_op;
   logic [3:0]      req0_rd, req1_rd, palu_cpr_rd_ben, rsp_rd, rsp_ben;
   logic            palu_ivalid, palu_idone, rsp_valid, rsp_ready, rsp_src, rsp_err;
   logic [31:0]     palu_cpr_rd_wdata, rsp_wdata;

   localparam logic [OP_W-1:0] OP_A = {32'hA0000001, 32'hA1, 32'hA2, 32'hA3, 32'h10, 3'd2, 4'd1, 5'd0};
   localparam logic [OP_W-1:0] OP_B = {32'hB0000002, 32'hB1, 32'hB2, 32'hB3, 32'h20, 3'd1, 4'd6, 5'd1};
   localparam logic [OP_W-1:0] OP_C = {32'hC0000003, 32'hC1, 32'hC2, 32'hC3, 32'h30, 3'd3, 4'd2, 5'd4};
   localparam logic [OP_W-1:0] OP_D = {32'hD0000004, 32'hD1, 32'hD2, 32'hD3, 32'h40, 3'd4, 4'd3, 5'd7};

   always #5 g_clk = ~g_clk;

   scarv_cop_palu_sched #(.TMO_CYCLES(8)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_rd(req0_rd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_rd(req1_rd),
      .palu_ivalid(palu_ivalid), .palu_op(palu_op), .palu_idone(palu_idone),
      .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_rd(rsp_rd),
      .rsp_ben(rsp_ben), .rsp_wdata(rsp_wdata), .rsp_err(rsp_err)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   initial begin
      req0_valid = 0; req1_valid = 0; req0_op = '0; req1_op = '0; req0_rd = 0; req1_rd = 0;
      palu_idone = 0; palu_cpr_rd_ben = 0; palu_cpr_rd_wdata = 0; rsp_ready = 0;
      #3;
      chk("rst_ivalid", palu_ivalid, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_palu_op", palu_op, '0);
      tick();
      g_resetn = 1;

      // 1: single op from req0, idone in first EXEC cycle
      req0_valid = 1; req0_op = OP_A; req0_rd = 4'd3;
      palu_idone = 1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'hDEADBEEF;
      #1;
      chk("t1_rdy0", req0_ready, 1'b1);
      chk("t1_rdy1", req1_ready, 1'b0);
      chk("t1_iv_c0", palu_ivalid, 1'b0);
      tick();
      req0_valid = 0;
      chk("t1_iv_c1", palu_ivalid, 1'b1);
      chk("t1_op", palu_op, OP_A);
      chk("t1_rspv_c1", rsp_valid, 1'b0);
      tick();
      chk("t1_rspv_c2", rsp_valid, 1'b1);
      chk("t1_iv_c2", palu_ivalid, 1'b0);
      chk("t1_src", rsp_src, 1'b0);
      chk("t1_rd", rsp_rd, 4'd3);
      chk("t1_ben", rsp_ben, 4'hF);
      chk("t1_wdata", rsp_wdata, 32'hDEADBEEF);
      chk("t1_err", rsp_err, 1'b0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("t1_idle_rspv", rsp_valid, 1'b0);

      // 2: both requesting continuously from fresh reset -> 0,1,0,1,0 back to back
      g_resetn = 0; #2; g_resetn = 1;
      req0_valid = 1; req0_op = OP_C; req0_rd = 4'd5;
      req1_valid = 1; req1_op = OP_D; req1_rd = 4'd9;
      rsp_ready = 1; palu_idone = 1;
      #1;
      chk("t2_rdy0", req0_ready, 1'b1);
      chk("t2_rdy1", req1_ready, 1'b0);
      tick();
      chk("t2_iv_first", palu_ivalid, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t2_rspv", rsp_valid, 1'b1);
         chk("t2_src", rsp_src, i[0]);
         chk("t2_rd", rsp_rd, i[0] ? 4'd9 : 4'd5);
         chk("t2_next_rdy", i[0] ? req0_ready : req1_ready, 1'b1);
         chk("t2_other_rdy", i[0] ? req1_ready : req0_ready, 1'b0);
         tick();
         chk("t2_iv", palu_ivalid, 1'b1);
         chk("t2_no_bubble", rsp_valid, 1'b0);
         chk("t2_op", palu_op, i[0] ? OP_C : OP_D);
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      chk("t2_last_src", rsp_src, 1'b0);
      tick();
      rsp_ready = 0;
      chk("t2_idle_rspv", rsp_valid, 1'b0);
      chk("t2_idle_iv", palu_ivalid, 1'b0);

      // 3: multi-cycle op from req1, idone on 4th EXEC cycle
      req1_valid = 1; req1_op = OP_B; req1_rd = 4'd7;
      palu_idone = 0; palu_cpr_rd_ben = 4'h3; palu_cpr_rd_wdata = 32'h12345678;
      #1;
      chk("t3_rdy1", req1_ready, 1'b1);
      tick();
      req1_valid = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) palu_idone = 1;
         #1;
         chk("t3_iv", palu_ivalid, 1'b1);
         chk("t3_op", palu_op, OP_B);
         chk("t3_rspv", rsp_valid, 1'b0);
         tick();
      end
      palu_idone = 0;
      chk("t3_iv_drop", palu_ivalid, 1'b0);
      chk("t3_rspv_up", rsp_valid, 1'b1);
      chk("t3_src", rsp_src, 1'b1);
      chk("t3_rd", rsp_rd, 4'd7);
      chk("t3_ben", rsp_ben, 4'h3);
      chk("t3_wdata", rsp_wdata, 32'h12345678);

      // 4: response back-pressure, then ben=0 response
      req0_valid = 1; req0_op = OP_C; req0_rd = 4'd5; req1_valid = 1;
      palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'hFFFF0000;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_rspv", rsp_valid, 1'b1);
         chk("t4_wdata", rsp_wdata, 32'h12345678);
         chk("t4_ben", rsp_ben, 4'h3);
         chk("t4_src", rsp_src, 1'b1);
         chk("t4_rdy0", req0_ready, 1'b0);
         chk("t4_rdy1", req1_ready, 1'b0);
         tick();
      end
      rsp_ready = 1;
      #1;
      chk("t4_rr_rdy0", req0_ready, 1'b1);
      chk("t4_rr_rdy1", req1_ready, 1'b0);
      tick();
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      palu_idone = 1; palu_cpr_rd_ben = 4'h0; palu_cpr_rd_wdata = 32'hCAFE0001;
      #1;
      chk("t4_iv", palu_ivalid, 1'b1);
      chk("t4_op", palu_op, OP_C);
      tick();
      palu_idone = 0;
      chk("t4_b0_rspv", rsp_valid, 1'b1);
      chk("t4_b0_src", rsp_src, 1'b0);
      chk("t4_b0_ben", rsp_ben, 4'h0);
      chk("t4_b0_wdata", rsp_wdata, 32'hCAFE0001);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;

`ifdef SCARV_COP_PALU_SCHED_TIMEOUT_EN
      // 5: watchdog fires after 8 EXEC cycles
      req0_valid = 1; req0_op = OP_A; req0_rd = 4'd2;
      palu_idone = 0; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h5555AAAA;
      tick();
      req0_valid = 0;
      for (int k = 0; k < 8; k++) begin
         chk("t5_iv", palu_ivalid, 1'b1);
         tick();
      end
      chk("t5_iv_drop", palu_ivalid, 1'b0);
      chk("t5_rspv", rsp_valid, 1'b1);
      chk("t5_err", rsp_err, 1'b1);
      chk("t5_ben", rsp_ben, 4'h0);
      chk("t5_wdata", rsp_wdata, 32'h0);
      chk("t5_rd", rsp_rd, 4'd2);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
`endif

      // 6: asynchronous reset mid-EXEC
      req1_valid = 1; req1_op = OP_D; req1_rd = 4'd9; palu_idone = 0;
      tick();
      req1_valid = 0;
      chk("t6_iv_pre", palu_ivalid, 1'b1);
      #2;
      g_resetn = 0;
      #1;
      chk("t6_iv_rst", palu_ivalid, 1'b0);
      chk("t6_rspv_rst", rsp_valid, 1'b0);
      tick();
      g_resetn = 1;
      tick();
      chk("t6_no_rsp", rsp_valid, 1'b0);
      req0_valid = 1; req0_op = OP_A; req0_rd = 4'd1; req1_valid = 1;
      #1;
      chk("t6_rdy0", req0_ready, 1'b1);
      chk("t6_rdy1", req1_ready, 1'b0);
      tick();
      req0_valid = 0; req1_valid = 0; palu_idone = 1;
      tick();
      palu_idone = 0;
      chk("t6_rspv", rsp_valid, 1'b1);
      chk("t6_src", rsp_src, 1'b0);
      chk("t6_rd", rsp_rd, 4'd1);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
